// File: rtl/axis_cnt_chk_pkg.sv
// Shared encodings for the AXI4-Stream count checker: FSM states and error-flag bit positions.
package axis_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam int unsigned FLAG_LANE = 0;
  localparam int unsigned FLAG_USER = 1;
  localparam int unsigned FLAG_SEQ  = 2;
  localparam int unsigned FLAG_LAST = 3;
  localparam int unsigned NUM_FLAGS = 4;

  typedef logic [NUM_FLAGS-1:0] err_flags_t;

  // A zero-length on-phase would stall the stream forever, so it is stretched to one cycle.
  function automatic logic [7:0] rdy_on_len(input logic [7:0] on_len);
    return (on_len == 8'd0) ? 8'd1 : on_len;
  endfunction

endpackage

// File: rtl/axis_cnt_chk_if.sv
// AXI4-Stream bundle carrying the replicated count lanes between counter source and checker.
interface axis_cnt_chk_if #(
  parameter int unsigned TDATA_DW  = 32,
  parameter int unsigned TDATA_QTY = 2,
  parameter int unsigned TUSER_DW  = 32
);
  logic [TDATA_QTY*TDATA_DW-1:0] tdata;
  logic [TUSER_DW-1:0]           tuser;
  logic                          tlast;
  logic                          tvalid;
  logic                          tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_cnt_chk_rdy.sv
// Backpressure pattern generator: on_len cycles ready, off_len cycles not ready, repeating.
module axis_cnt_chk_rdy
  import axis_cnt_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       restart_i,
  input  logic       en_i,
  input  logic [7:0] on_len_i,
  input  logic [7:0] off_len_i,
  output logic       rdy_o
);

  logic       on_q, on_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] on_len;
  logic [8:0] cnt_inc;

  always_comb begin
    on_len  = rdy_on_len(on_len_i);
    cnt_inc = {1'b0, cnt_q} + 9'd1;
    on_d    = on_q;
    cnt_d   = cnt_q;
    if (restart_i) begin
      on_d  = 1'b1;
      cnt_d = '0;
    end else if (en_i) begin
      if (on_q) begin
        if (cnt_inc >= {1'b0, on_len}) begin
          cnt_d = '0;
          on_d  = (off_len_i == 8'd0);
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end else begin
        if (cnt_inc >= {1'b0, off_len_i}) begin
          cnt_d = '0;
          on_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      on_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      on_q  <= on_d;
      cnt_q <= cnt_d;
    end
  end

  // off_len of zero forces ready even if a stale off-phase is still pending.
  assign rdy_o = en_i & (on_q | (off_len_i == 8'd0));

endmodule

// File: rtl/axis_cnt_chk.sv
// AXI4-Stream sink that applies a ready pattern, checks each accepted beat against the
// expected count sequence and accumulates beat/frame/error statistics.
module axis_cnt_chk
  import axis_cnt_pkg::*;
#(
  parameter int unsigned TDATA_DW  = 32,
  parameter int unsigned TDATA_QTY = 2,
  parameter int unsigned TUSER_DW  = 32,
  parameter int unsigned ERR_DW    = 16
) (
  input  logic                m_axis_aclk,
  input  logic                m_axis_aresetn,
  axis_cnt_chk_if.slave       s_axis,
  input  logic [TDATA_DW-1:0] max_value_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                halt_on_err_i,
  input  logic [7:0]          rdy_on_i,
  input  logic [7:0]          rdy_off_i,
  output logic [31:0]         beat_cnt_o,
  output logic [31:0]         frame_cnt_o,
  output logic [ERR_DW-1:0]   err_cnt_o,
  output logic [15:0]         lost_last_cnt_o,
  output logic [3:0]          err_flags_o,
  output logic [TDATA_DW-1:0] first_err_val_o,
  output logic [1:0]          state_o
);

  state_e state_q, state_d;

  logic rdy_en, restart, rdy, accept;
  logic in_sync, in_check;

  logic [TDATA_DW-1:0] v, m_len;
  logic [TDATA_DW:0]   v_inc;
  logic                wrap;
  logic                lane_mis, seq_mis, lost_hit;
  err_flags_t          flags_now;

  logic [TDATA_DW-1:0] exp_q, exp_d;

  logic                res_vld_q, res_vld_d;
  err_flags_t          res_flags_q, res_flags_d;
  logic                res_last_q, res_last_d;
  logic                res_lost_q, res_lost_d;
  logic [TDATA_DW-1:0] res_val_q, res_val_d;

  logic [31:0]         beat_cnt_q, beat_cnt_d;
  logic [31:0]         frame_cnt_q, frame_cnt_d;
  logic [ERR_DW-1:0]   err_cnt_q, err_cnt_d;
  logic [15:0]         lost_cnt_q, lost_cnt_d;
  err_flags_t          flags_q, flags_d;
  logic [TDATA_DW-1:0] first_err_q, first_err_d;

  axis_cnt_chk_rdy u_rdy (
    .clk_i     (m_axis_aclk),
    .rst_ni    (m_axis_aresetn),
    .restart_i (restart),
    .en_i      (rdy_en),
    .on_len_i  (rdy_on_i),
    .off_len_i (rdy_off_i),
    .rdy_o     (rdy)
  );

  assign s_axis.tready = rdy;
  assign accept        = s_axis.tvalid & rdy;

  // Beat comparators; all widened by one bit so v+1 never wraps.
  always_comb begin
    v        = s_axis.tdata[TDATA_DW-1:0];
    m_len    = (max_value_i == '0) ? TDATA_DW'(1) : max_value_i;
    v_inc    = {1'b0, v} + (TDATA_DW+1)'(1);
    wrap     = (v_inc >= {1'b0, max_value_i});
    in_sync  = (state_q == ST_SYNC);
    in_check = (state_q == ST_CHECK);
    lane_mis = 1'b0;
    for (int unsigned i = 1; i < TDATA_QTY; i++) begin
      if (s_axis.tdata[i*TDATA_DW +: TDATA_DW] != v) lane_mis = 1'b1;
    end
    seq_mis  = in_check && (v != exp_q);
    lost_hit = seq_mis && (v == '0) && (exp_q == m_len - TDATA_DW'(1));
    flags_now            = '0;
    flags_now[FLAG_LANE] = lane_mis;
    flags_now[FLAG_USER] = (s_axis.tuser != v[TUSER_DW-1:0]);
    flags_now[FLAG_SEQ]  = seq_mis && !lost_hit;
    flags_now[FLAG_LAST] = in_check && (s_axis.tlast != wrap);
  end

  // FSM: state register
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // FSM: next state; stop_i takes priority over everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i && !stop_i) state_d = ST_SYNC;
      ST_SYNC:  if (stop_i) state_d = ST_IDLE;
                else if (accept) state_d = ST_CHECK;
      ST_CHECK: if (stop_i) state_d = ST_IDLE;
                else if (accept && (|flags_now) && halt_on_err_i) state_d = ST_HALT;
      ST_HALT:  if (stop_i) state_d = ST_IDLE;
                else if (start_i) state_d = ST_SYNC;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rdy_en  = in_sync || in_check;
    restart = (state_d == ST_SYNC) && (state_q != ST_SYNC);
    state_o = state_q;
  end

  // Expected value tracking and one-stage result register
  always_comb begin
    exp_d       = exp_q;
    res_vld_d   = accept;
    res_flags_d = accept ? flags_now : '0;
    res_last_d  = accept & s_axis.tlast;
    res_lost_d  = accept & lost_hit;
    res_val_d   = accept ? v : res_val_q;
    if (accept && in_sync) begin
      exp_d = s_axis.tlast ? '0 : v_inc[TDATA_DW-1:0];
    end else if (accept && in_check) begin
      exp_d = wrap ? '0 : v_inc[TDATA_DW-1:0];
    end
  end

  // Statistics; entry into SYNC clears them, otherwise they follow the result register.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    lost_cnt_d  = lost_cnt_q;
    flags_d     = flags_q;
    first_err_d = first_err_q;
    if (restart) begin
      beat_cnt_d  = '0;
      frame_cnt_d = '0;
      err_cnt_d   = '0;
      lost_cnt_d  = '0;
      flags_d     = '0;
      first_err_d = '0;
    end else if (res_vld_q) begin
      beat_cnt_d  = beat_cnt_q + 32'(1);
      frame_cnt_d = frame_cnt_q + 32'(res_last_q);
      lost_cnt_d  = lost_cnt_q + 16'(res_lost_q);
      flags_d     = flags_q | res_flags_q;
      if (|res_flags_q) begin
        if (err_cnt_q == '0) first_err_d = res_val_q;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_DW'(1);
      end
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      exp_q       <= '0;
      res_vld_q   <= 1'b0;
      res_flags_q <= '0;
      res_last_q  <= 1'b0;
      res_lost_q  <= 1'b0;
      res_val_q   <= '0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      lost_cnt_q  <= '0;
      flags_q     <= '0;
      first_err_q <= '0;
    end else begin
      exp_q       <= exp_d;
      res_vld_q   <= res_vld_d;
      res_flags_q <= res_flags_d;
      res_last_q  <= res_last_d;
      res_lost_q  <= res_lost_d;
      res_val_q   <= res_val_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
      flags_q     <= flags_d;
      first_err_q <= first_err_d;
    end
  end

  assign beat_cnt_o      = beat_cnt_q;
  assign frame_cnt_o     = frame_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign lost_last_cnt_o = lost_cnt_q;
  assign err_flags_o     = flags_q;
  assign first_err_val_o = first_err_q;

endmodule

// File: tb/tb_axis_cnt_chk.sv
// Directed bench for axis_cnt_chk: table of beats with expected running statistics plus
// hand-written sequences for backpressure, halt, lost-last, short frames and reset.
module tb_axis_cnt_chk;

  localparam logic [1:0] S_IDLE = 2'd0, S_SYNC = 2'd1, S_CHECK = 2'd2, S_HALT = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] max_value;
  logic        start, stop, halt;
  logic [7:0]  rdy_on, rdy_off;
  logic [31:0] beat_cnt, frame_cnt, first_err;
  logic [15:0] err_cnt, lost_cnt;
  logic [3:0]  flags;
  logic [1:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axis_cnt_chk_if #(.TDATA_DW(32), .TDATA_QTY(2), .TUSER_DW(32)) bus ();

  axis_cnt_chk #(.TDATA_DW(32), .TDATA_QTY(2), .TUSER_DW(32), .ERR_DW(16)) dut (
    .m_axis_aclk     (clk),
    .m_axis_aresetn  (rstn),
    .s_axis          (bus),
    .max_value_i     (max_value),
    .start_i         (start),
    .stop_i          (stop),
    .halt_on_err_i   (halt),
    .rdy_on_i        (rdy_on),
    .rdy_off_i       (rdy_off),
    .beat_cnt_o      (beat_cnt),
    .frame_cnt_o     (frame_cnt),
    .err_cnt_o       (err_cnt),
    .lost_last_cnt_o (lost_cnt),
    .err_flags_o     (flags),
    .first_err_val_o (first_err),
    .state_o         (state)
  );

  typedef struct packed {
    logic [31:0] l0, l1, usr;
    logic        last;
    logic [31:0] beats;
    logic [15:0] errs;
    logic [3:0]  flg;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic [31:0] l0, l1, usr, input logic last,
                              input logic [31:0] beats, input logic [15:0] errs,
                              input logic [3:0] flg, input logic [1:0] st);
    vec_t r;
    r.l0 = l0; r.l1 = l1; r.usr = usr; r.last = last;
    r.beats = beats; r.errs = errs; r.flg = flg; r.st = st;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  // Hold the beat until the sink is ready; ready never depends on tvalid, so the
  // value seen at the falling edge is the one used at the next rising edge.
  task automatic send(input logic [31:0] l0, input logic [31:0] l1,
                      input logic [31:0] usr, input logic last);
    logic acc;
    acc = 1'b0;
    bus.tdata  = {l1, l0};
    bus.tuser  = usr;
    bus.tlast  = last;
    bus.tvalid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      if (bus.tready) acc = 1'b1;
      @(posedge clk); #1;
    end
    bus.tvalid = 1'b0;
    chk("beat_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_run(input int first, input int lastv, input logic mark_last);
    for (int v = first; v <= lastv; v++)
      send(32'(v), 32'(v), 32'(v), mark_last && (v == lastv));
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] b, input logic [31:0] f,
                           input logic [15:0] e, input logic [15:0] l, input logic [3:0] fl);
    chk({tag, "_beat"},  64'(beat_cnt),  64'(b));
    chk({tag, "_frame"}, 64'(frame_cnt), 64'(f));
    chk({tag, "_err"},   64'(err_cnt),   64'(e));
    chk({tag, "_lost"},  64'(lost_cnt),  64'(l));
    chk({tag, "_flags"}, 64'(flags),     64'(fl));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; max_value = 32'd8; start = 1'b0; stop = 1'b0; halt = 1'b0;
    rdy_on = 8'd1; rdy_off = 8'd0;
    bus.tdata = '0; bus.tuser = '0; bus.tlast = 1'b0; bus.tvalid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_state", 64'(state), 64'(S_IDLE));
    chk("rst_tready", 64'(bus.tready), 64'd0);
    chk("rst_first_err", 64'(first_err), 64'd0);
    chk_stats("rst", 0, 0, 0, 0, 4'b0000);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("start_stop_same", 64'(state), 64'(S_IDLE));

    // Always ready, 3 clean frames of 0..7
    pulse_start();
    chk("sync_state", 64'(state), 64'(S_SYNC));
    chk("sync_tready", 64'(bus.tready), 64'd1);
    repeat (3) send_run(0, 7, 1'b1);
    settle();
    chk("clean_state", 64'(state), 64'(S_CHECK));
    chk_stats("clean", 24, 3, 0, 0, 4'b0000);
    pulse_stop();
    chk("stop_state", 64'(state), 64'(S_IDLE));
    chk("idle_tready", 64'(bus.tready), 64'd0);
    chk("idle_held_beat", 64'(beat_cnt), 64'd24);

    // Backpressure pattern 2 on / 3 off, restarting in the on phase
    rdy_on = 8'd2; rdy_off = 8'd3;
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("pattern_c%0d", i), 64'(bus.tready), 64'((i % 5) < 2));
    end
    @(posedge clk); #1;
    repeat (3) send_run(0, 7, 1'b1);
    settle();
    chk_stats("pattern", 24, 3, 0, 0, 4'b0000);
    pulse_stop();

    // Error injection table, max=8, no halt
    rdy_on = 8'd1; rdy_off = 8'd0;
    vecs[0]  = mk(0, 0, 0, 0,  1, 0, 4'b0000, S_CHECK);
    vecs[1]  = mk(1, 1, 1, 0,  2, 0, 4'b0000, S_CHECK);
    vecs[2]  = mk(2, 2, 2, 0,  3, 0, 4'b0000, S_CHECK);
    vecs[3]  = mk(3, 3, 3, 0,  4, 0, 4'b0000, S_CHECK);
    vecs[4]  = mk(4, 5, 4, 0,  5, 1, 4'b0001, S_CHECK);
    vecs[5]  = mk(5, 5, 5, 0,  6, 1, 4'b0001, S_CHECK);
    vecs[6]  = mk(6, 6, 7, 0,  7, 2, 4'b0011, S_CHECK);
    vecs[7]  = mk(7, 7, 7, 0,  8, 3, 4'b1011, S_CHECK);
    vecs[8]  = mk(0, 0, 0, 1,  9, 4, 4'b1011, S_CHECK);
    vecs[9]  = mk(1, 1, 1, 0, 10, 4, 4'b1011, S_CHECK);
    vecs[10] = mk(3, 3, 3, 0, 11, 5, 4'b1111, S_CHECK);
    vecs[11] = mk(4, 4, 4, 0, 12, 5, 4'b1111, S_CHECK);
    pulse_start();
    chk("err_start_clear", 64'(beat_cnt), 64'd0);
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].l0, vecs[i].l1, vecs[i].usr, vecs[i].last);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_beat", i),  64'(beat_cnt), 64'(vecs[i].beats));
      chk($sformatf("vec%0d_err", i),   64'(err_cnt),  64'(vecs[i].errs));
      chk($sformatf("vec%0d_flags", i), 64'(flags),    64'(vecs[i].flg));
      chk($sformatf("vec%0d_state", i), 64'(state),    64'(vecs[i].st));
    end
    chk("vec_first_err", 64'(first_err), 64'd4);
    chk("vec_frames", 64'(frame_cnt), 64'd1);
    pulse_stop();

    // Skipped value with halt_on_err
    halt = 1'b1;
    pulse_start();
    send_run(0, 2, 1'b0);
    send(4, 4, 4, 1'b0);
    chk("halt_state", 64'(state), 64'(S_HALT));
    chk("halt_tready", 64'(bus.tready), 64'd0);
    @(posedge clk); #1;
    chk_stats("halt", 4, 0, 1, 0, 4'b0100);
    chk("halt_first_err", 64'(first_err), 64'd4);
    bus.tdata = {32'd5, 32'd5}; bus.tuser = 32'd5; bus.tvalid = 1'b1;
    repeat (5) @(posedge clk); #1;
    bus.tvalid = 1'b0;
    chk("halt_frozen_tready", 64'(bus.tready), 64'd0);
    chk("halt_frozen_beat", 64'(beat_cnt), 64'd4);
    pulse_start();
    chk("restart_state", 64'(state), 64'(S_SYNC));
    chk_stats("restart", 0, 0, 0, 0, 4'b0000);
    chk("restart_first_err", 64'(first_err), 64'd0);
    pulse_stop();
    halt = 1'b0;

    // Last beat of a frame never accepted: frame restarts at 0
    pulse_start();
    send_run(0, 6, 1'b0);
    send_run(0, 7, 1'b1);
    settle();
    chk_stats("lost", 15, 1, 0, 1, 4'b0000);
    pulse_stop();

    // Single-beat frames with max 1 and max 0
    max_value = 32'd1;
    pulse_start();
    repeat (4) send(0, 0, 0, 1'b1);
    max_value = 32'd0;
    repeat (2) send(0, 0, 0, 1'b1);
    settle();
    chk_stats("max01", 6, 6, 0, 0, 4'b0000);

    // Reset in the middle of a presented beat
    bus.tdata = '0; bus.tuser = '0; bus.tlast = 1'b1; bus.tvalid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_state", 64'(state), 64'(S_IDLE));
    chk("midrst_tready", 64'(bus.tready), 64'd0);
    chk("midrst_first_err", 64'(first_err), 64'd0);
    chk_stats("midrst", 0, 0, 0, 0, 4'b0000);
    @(negedge clk);
    bus.tvalid = 1'b0;
    rstn = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("post_rst_state", 64'(state), 64'(S_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
